// File: rtl/karatsuba_recomb.sv
// Karatsuba recombination: folds z0, z2, z1 into z2*2^2m + mid*2^m + z0.
// Optional input consistency checking under KARATSUBA_RECOMB_CHECK_EN.
module karatsuba_recomb #(
  parameter int N_HALF = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [2*N_HALF+1:0]   p_data,
  input  logic                  p_valid,
  output logic                  p_ready,
  output logic [4*N_HALF-1:0]   r_data,
  output logic                  r_valid,
  input  logic                  r_ready,
  output logic                  err
);

  localparam int M  = N_HALF;
  localparam int W2 = 2 * N_HALF;
  localparam int W4 = 4 * N_HALF;

  typedef enum logic [1:0] {
    S_Z0,
    S_Z2,
    S_Z1,
    S_OUT
  } state_t;

  state_t          state;
  state_t          state_nxt;
  logic [W2-1:0]   z0_q;
  logic [W2-1:0]   z2_q;
  logic [W4-1:0]   r_data_q;
  logic            in_xfer;
  logic            cap_z0;
  logic            cap_z2;
  logic            cap_z1;
  logic [W2+1:0]   mid;
  logic [W4-1:0]   sum;

  assign in_xfer = p_valid && p_ready;
  assign cap_z0  = in_xfer && ((state == S_Z0) || (state == S_OUT));
  assign cap_z2  = in_xfer && (state == S_Z2);
  assign cap_z1  = in_xfer && (state == S_Z1);
  assign r_valid = (state == S_OUT);
  assign r_data  = r_data_q;

  // Middle term wraps modulo 2^(2m+2); the final sum wraps modulo 2^4m.
  assign mid = p_data - {2'b00, z2_q} - {2'b00, z0_q};
  assign sum = {z2_q, {W2{1'b0}}}
             + ({{(W2-2){1'b0}}, mid} << M)
             + {{W2{1'b0}}, z0_q};

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_Z0;
    else        state <= state_nxt;
  end

  // Next state and input handshake.
  always_comb begin
    state_nxt = state;
    p_ready   = 1'b1;
    unique case (state)
      S_Z0: if (p_valid) state_nxt = S_Z2;
      S_Z2: if (p_valid) state_nxt = S_Z1;
      S_Z1: if (p_valid) state_nxt = S_OUT;
      S_OUT: begin
        p_ready = r_ready;
        if (r_ready) state_nxt = p_valid ? S_Z2 : S_Z0;
      end
      default: state_nxt = S_Z0;
    endcase
  end

  // Operand captures and result register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      z0_q     <= '0;
      z2_q     <= '0;
      r_data_q <= '0;
    end else begin
      if (cap_z0) z0_q <= p_data[W2-1:0];
      if (cap_z2) z2_q <= p_data[W2-1:0];
      if (cap_z1) r_data_q <= sum;
    end
  end

`ifdef KARATSUBA_RECOMB_CHECK_EN
  logic          err_q;
  logic [W2:0]   zsum;

  assign zsum = {1'b0, z0_q} + {1'b0, z2_q};
  assign err  = err_q;

  // Sticky flag: stray high bits on z0/z2, or z1 too small for the pair.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_q <= 1'b0;
    end else begin
      if ((cap_z0 || cap_z2) && (|p_data[W2+1:W2])) err_q <= 1'b1;
      if (cap_z1 && (p_data < {1'b0, zsum}))        err_q <= 1'b1;
    end
  end
`else
  assign err = 1'b0;
`endif

endmodule
